// File: rtl/usb_rx_pkg.sv
// -----------------------------------------------------------------------------
// usb_rx_pkg
// Shared definitions for the USB receive path.
//   STUFF_LEN_DEFAULT : number of consecutive 1s after which a stuffed 0 follows
//   unstuff_state_t   : state encoding of the bit unstuffer controller
// -----------------------------------------------------------------------------
package usb_rx_pkg;

  localparam int STUFF_LEN_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for start_unstuffer
    ST_RUN   = 2'd1,  // forwarding packet bits
    ST_STUFF = 2'd2,  // current bit is the stuffed bit, must be 0
    ST_ABORT = 2'd3   // stuffing violation seen, data suppressed until end
  } unstuff_state_t;

endpackage

// File: rtl/rc_unstuffer_fsm.sv
// -----------------------------------------------------------------------------
// rc_unstuffer_fsm
// Control FSM of the bit unstuffer. Produces per-cycle decisions that the
// parent registers into its outputs and its ones counter.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_s_in        : current serial bit
//   i_start       : start_unstuffer pulse
//   i_end         : end_unstuffer pulse
//   i_ones_last   : ones counter is one short of the stuffing threshold
//   o_start_p     : emit start_decoder next cycle
//   o_end_p       : emit end_decoder next cycle
//   o_err_p       : emit stuff_err next cycle
//   o_valid       : current s_in is a real data bit to forward
//   o_cnt_clr     : clear the ones counter
//   o_cnt_inc     : increment the ones counter
// -----------------------------------------------------------------------------
module rc_unstuffer_fsm
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_s_in,
  input  logic i_start,
  input  logic i_end,
  input  logic i_ones_last,
  output logic o_start_p,
  output logic o_end_p,
  output logic o_err_p,
  output logic o_valid,
  output logic o_cnt_clr,
  output logic o_cnt_inc
);

  unstuff_state_t r_state;
  unstuff_state_t w_state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_start_p    = 1'b0;
    o_end_p      = 1'b0;
    o_err_p      = 1'b0;
    o_valid      = 1'b0;
    o_cnt_clr    = 1'b0;
    o_cnt_inc    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // start wins over a simultaneous end; everything else is ignored
        if (i_start) begin
          o_start_p    = 1'b1;
          o_cnt_clr    = 1'b1;
          w_state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        // end has priority over the data bit presented in the same cycle
        if (i_end) begin
          o_end_p      = 1'b1;
          o_cnt_clr    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          o_valid = 1'b1;
          if (i_s_in) begin
            o_cnt_inc = 1'b1;
            // this 1 completes the run, so the following bit is stuffed
            if (i_ones_last) begin
              w_state_next = ST_STUFF;
            end
          end else begin
            o_cnt_clr = 1'b1;
          end
        end
      end

      ST_STUFF: begin
        if (i_end) begin
          // ending on the stuffed bit position is legal
          o_end_p      = 1'b1;
          o_cnt_clr    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          o_cnt_clr = 1'b1;
          if (i_s_in) begin
            o_err_p      = 1'b1;
            w_state_next = ST_ABORT;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end

      ST_ABORT: begin
        if (i_end) begin
          o_end_p      = 1'b1;
          o_cnt_clr    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/rc_unstuffer.sv
// -----------------------------------------------------------------------------
// rc_unstuffer
// USB bit unstuffer. Removes the 0 inserted after every STUFF_LEN consecutive
// 1s, flags a stuffing violation and frames the packet for the decoder.
// All outputs are registered (one cycle latency from the inputs).
//   clk             : clock
//   rst_n           : asynchronous active-low reset
//   s_in            : NRZI-decoded serial bit
//   start_unstuffer : packet start pulse; first bit follows next cycle
//   end_unstuffer   : packet end pulse; s_in not a packet bit this cycle
//   s_out           : unstuffed data bit (holds when bit_valid is low)
//   bit_valid       : s_out carries a real data bit
//   start_decoder   : start pulse to the downstream stage
//   end_decoder     : end pulse to the downstream stage
//   stuff_err       : bit-stuffing violation pulse
// -----------------------------------------------------------------------------
module rc_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_in,
  input  logic start_unstuffer,
  input  logic end_unstuffer,
  output logic s_out,
  output logic bit_valid,
  output logic start_decoder,
  output logic end_decoder,
  output logic stuff_err
);

  localparam int CNT_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STUFF_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STUFF_LEN);

  logic [CNT_W-1:0] r_ones_cnt;
  logic             r_s_out;
  logic             r_bit_valid;
  logic             r_start_decoder;
  logic             r_end_decoder;
  logic             r_stuff_err;

  logic w_ones_last;
  logic w_start_p;
  logic w_end_p;
  logic w_err_p;
  logic w_valid;
  logic w_cnt_clr;
  logic w_cnt_inc;

  assign w_ones_last = (r_ones_cnt == CNT_LAST);

  rc_unstuffer_fsm u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_s_in      (s_in),
    .i_start     (start_unstuffer),
    .i_end       (end_unstuffer),
    .i_ones_last (w_ones_last),
    .o_start_p   (w_start_p),
    .o_end_p     (w_end_p),
    .o_err_p     (w_err_p),
    .o_valid     (w_valid),
    .o_cnt_clr   (w_cnt_clr),
    .o_cnt_inc   (w_cnt_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_cnt      <= '0;
      r_s_out         <= 1'b0;
      r_bit_valid     <= 1'b0;
      r_start_decoder <= 1'b0;
      r_end_decoder   <= 1'b0;
      r_stuff_err     <= 1'b0;
    end else begin
      r_bit_valid     <= w_valid;
      r_start_decoder <= w_start_p;
      r_end_decoder   <= w_end_p;
      r_stuff_err     <= w_err_p;
      // s_out only moves with a real data bit, otherwise it keeps its value
      if (w_valid) begin
        r_s_out <= s_in;
      end
      // counter saturates at the threshold rather than wrapping
      if (w_cnt_clr) begin
        r_ones_cnt <= '0;
      end else if (w_cnt_inc && (r_ones_cnt != CNT_MAX)) begin
        r_ones_cnt <= r_ones_cnt + CNT_W'(1);
      end
    end
  end

  assign s_out         = r_s_out;
  assign bit_valid     = r_bit_valid;
  assign start_decoder = r_start_decoder;
  assign end_decoder   = r_end_decoder;
  assign stuff_err     = r_stuff_err;

endmodule

// File: tb/tb_rc_unstuffer.sv
// -----------------------------------------------------------------------------
// tb_rc_unstuffer
// Self-checking bench for rc_unstuffer. A packet-level reference model predicts
// the outputs every cycle; directed scenarios also check recorded output
// sequences against hand-written literal tables.
// Output vectors are packed as {start_decoder, end_decoder, stuff_err,
// bit_valid, s_out}.
// -----------------------------------------------------------------------------
module tb_rc_unstuffer;

  localparam int SL = 6;

  logic clk;
  logic rst_n;
  logic s_in;
  logic start_unstuffer;
  logic end_unstuffer;
  logic s_out;
  logic bit_valid;
  logic start_decoder;
  logic end_decoder;
  logic stuff_err;

  int n_cmp;
  int n_err;

  rc_unstuffer #(.STUFF_LEN(SL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_in            (s_in),
    .start_unstuffer (start_unstuffer),
    .end_unstuffer   (end_unstuffer),
    .s_out           (s_out),
    .bit_valid       (bit_valid),
    .start_decoder   (start_decoder),
    .end_decoder     (end_decoder),
    .stuff_err       (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Packet view: inside a packet, a run of SL ones makes the next bit a stuff
  // position; a 0 there is dropped, a 1 there kills the rest of the packet.
  bit   m_in_pkt;
  bit   m_dead;
  bit   m_stuff_next;
  int   m_run;
  logic m_start, m_end, m_err, m_valid, m_sout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_pkt = 0; m_dead = 0; m_stuff_next = 0; m_run = 0;
      m_start = 0; m_end = 0; m_err = 0; m_valid = 0; m_sout = 0;
    end else begin
      m_start = 0; m_end = 0; m_err = 0; m_valid = 0;
      if (!m_in_pkt) begin
        if (start_unstuffer) begin
          m_start = 1; m_in_pkt = 1; m_dead = 0; m_stuff_next = 0; m_run = 0;
        end
      end else if (end_unstuffer) begin
        m_end = 1; m_in_pkt = 0;
      end else if (m_dead) begin
        // suppressed until end
      end else if (m_stuff_next) begin
        m_stuff_next = 0;
        m_run = 0;
        if (s_in) begin
          m_err = 1; m_dead = 1;
        end
      end else begin
        m_valid = 1;
        m_sout  = s_in;
        m_run   = s_in ? m_run + 1 : 0;
        if (m_run == SL) m_stuff_next = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [4:0] hist[$];

  always @(posedge clk) begin
    logic [4:0] act, req;
    #2;
    act = {start_decoder, end_decoder, stuff_err, bit_valid, s_out};
    req = {m_start, m_end, m_err, m_valid, m_sout};
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL cycle_model t=%0t: got %05b want %05b", $time, act, req);
    end
    hist.push_back(act);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %05b want %05b", nm, act, req);
    end
  endtask

  // called at a negedge; returns at the next negedge
  task automatic drive(input logic b, input logic st, input logic en);
    s_in = b; start_unstuffer = st; end_unstuffer = en;
    $display("tx t=%0t s_in=%0b start=%0b end=%0b", $time, b, st, en);
    @(negedge clk);
  endtask

  task automatic drive_ones(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_hist(input string nm, input logic [4:0] e[$]);
    n_cmp++;
    if (hist.size() != e.size()) begin
      n_err++;
      $display("FAIL %s_len: got %0d want %0d", nm, hist.size(), e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) chk($sformatf("%s[%0d]", nm, i), hist[i], e[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] exp_q[$];

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b1; s_in = 1'b0; start_unstuffer = 1'b0; end_unstuffer = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", {start_decoder, end_decoder, stuff_err, bit_valid, s_out}, 5'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1);  // end and data in IDLE: ignored
    drive(1'b1, 1'b0, 1'b0);

    // basic packet 1,0,1,1,0
    hist.delete();
    drive(0,1,0); drive(1,0,0); drive(0,0,0); drive(1,0,0);
    drive(1,0,0); drive(0,0,0); drive(0,0,1); drive(0,0,0);
    exp_q = '{5'b10000, 5'b00011, 5'b00010, 5'b00011,
              5'b00011, 5'b00010, 5'b01000, 5'b00000};
    check_hist("basic", exp_q);

    // six 1s, stuffed 0 dropped, then 1
    hist.delete();
    drive(0,1,0); drive_ones(6); drive(0,0,0); drive(1,0,0); drive(0,0,1); drive(0,0,0);
    exp_q = '{5'b10000, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011,
              5'b00011, 5'b00001, 5'b00011, 5'b01001, 5'b00001};
    check_hist("stuff_ok", exp_q);

    // six 1s then 1: violation, data suppressed until end
    hist.delete();
    drive(0,1,0); drive_ones(6); drive(1,0,0); drive(1,0,0); drive(0,0,0);
    drive(0,0,1); drive(0,0,0);
    exp_q = '{5'b10001, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011,
              5'b00011, 5'b00101, 5'b00001, 5'b00001, 5'b01001, 5'b00001};
    check_hist("stuff_err", exp_q);

    // end arriving on the stuff position
    hist.delete();
    drive(0,1,0); drive_ones(6); drive(1,0,1); drive(0,0,0);
    exp_q = '{5'b10001, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011,
              5'b00011, 5'b01001, 5'b00001};
    check_hist("end_in_stuff", exp_q);

    // five 1s, 0, five 1s: run broken, no stuffing expected
    hist.delete();
    drive(0,1,0); drive_ones(5); drive(0,0,0); drive_ones(5); drive(0,0,0);
    drive(0,0,1); drive(0,0,0);
    exp_q = '{5'b10001, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011,
              5'b00010, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00011,
              5'b00010, 5'b01000, 5'b00000};
    check_hist("run_break", exp_q);

    // reset in the middle of a packet
    drive(0,1,0); drive(1,0,0); drive(0,0,0); drive(1,0,0);
    chk("pre_reset", {start_decoder, end_decoder, stuff_err, bit_valid, s_out}, 5'b00011);
    #3 rst_n = 1'b0;
    #1 chk("mid_reset", {start_decoder, end_decoder, stuff_err, bit_valid, s_out}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    drive(1,0,0); drive(1,0,1); drive(1,0,0);
    exp_q = '{5'b00000, 5'b00000, 5'b00000};
    check_hist("post_reset_quiet", exp_q);
    hist.delete();
    drive(0,1,0); drive(0,0,0); drive(1,0,0); drive(0,0,1); drive(0,0,0);
    exp_q = '{5'b10000, 5'b00010, 5'b00011, 5'b01001, 5'b00001};
    check_hist("post_reset_pkt", exp_q);

    // start while running is ignored
    hist.delete();
    drive(0,1,0); drive(1,0,0); drive(1,1,0); drive(0,0,0); drive(0,0,1); drive(0,0,0);
    exp_q = '{5'b10001, 5'b00011, 5'b00011, 5'b00010, 5'b01000, 5'b00000};
    check_hist("start_in_run", exp_q);

    // start and end together in IDLE: start wins
    hist.delete();
    drive(0,1,1); drive(1,0,0); drive(0,0,1); drive(0,0,0);
    exp_q = '{5'b10000, 5'b00011, 5'b01001, 5'b00001};
    check_hist("start_end_idle", exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
